chaser_sequencer: RTL and testbench

- Controller that sequences an LED chaser pattern through programmable modes, speed and pass count.
- Accepts one configuration word per run through a valid/ready handshake, then produces the pattern directly on led_out.
- Sits between the board-level control logic (buttons or CSR) and the LEDs. It replaces fixed free-running rotation with a managed run that can pause, stop and signal completion.

---
 rtl/chaser_pkg.sv | 18 +
 rtl/chaser_step_timer.sv | 30 +++
 rtl/chaser_sequencer.sv | 139 +++++++++++++
 tb/tb_chaser_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/chaser_pkg.sv
// Shared types and helpers for the LED chaser sequencer.
package chaser_pkg;

   typedef enum logic [1:0] {ROT_L, ROT_R, BOUNCE, FILL} mode_t;
   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

   // Number of steps after which the pattern is back at its start value.
   function automatic int pass_len(mode_t m, int width);
      int len;
      case (m)
         ROT_L, ROT_R: len = width;
         BOUNCE:       len = 2 * (width - 1);
         default:      len = 2 * width;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/chaser_step_timer.sv
// Step prescaler: counts 0..max(period,1)-1 while run is high and pulses step on the last count.
module chaser_step_timer #(
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          run,
   input  logic [PW-1:0] period,
   output logic          at_end,
   output logic          step
);

   logic [PW-1:0] cnt;
   logic [PW-1:0] last;

   // A period of zero behaves like one: every cycle is a step.
   assign last   = (period == '0) ? '0 : period - 1'b1;
   assign at_end = (cnt == last);
   assign step   = run && at_end;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= at_end ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/chaser_sequencer.sv
// LED chaser run controller: accepts one config per run, steps a pattern on led_out,
// supports pause, abort and a one-cycle done pulse at the end of the final pass.
module chaser_sequencer
   import chaser_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PW    = 16,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [PW-1:0]    cfg_period,
   input  logic [CW-1:0]    cfg_cycles,
   input  logic             enable,
   input  logic             stop,
   output logic [WIDTH-1:0] led_out,
   output logic             busy,
   output logic             done
);

   localparam int SW = $clog2(2 * WIDTH);

   state_t           state, state_nx;
   mode_t            mode_r;
   logic [PW-1:0]    period_r;
   logic [CW-1:0]    cycles_r, pass_cnt;
   logic [SW-1:0]    step_cnt, last_step;
   logic             dir_r;
   logic             done_r;
   logic [WIDTH-1:0] led_r, led_nx, start_pat;
   logic             accept, in_run, pass_end, last_pass, final_step, advance;
   logic             at_end, step;

   // Handshake: a config word transfers on any cycle where cfg_valid and cfg_ready are
   // both high; cfg_ready is high only in IDLE and DONE, so words offered mid-run are ignored.
   assign cfg_ready  = (state == IDLE) || (state == DONE);
   assign accept     = cfg_valid && cfg_ready;
   assign in_run     = (state == RUN);
   assign busy       = (state == RUN) || (state == HOLD);
   assign led_out    = led_r;
   assign done       = done_r;

   assign last_step  = SW'(pass_len(mode_r, WIDTH) - 1);
   assign pass_end   = (step_cnt == last_step);
   assign last_pass  = (cycles_r != '0) && (pass_cnt + CW'(1) == cycles_r);
   // The final step completes even when enable drops on the same cycle.
   assign final_step = in_run && at_end && pass_end && last_pass && !stop;
   assign advance    = in_run && !stop && (enable || final_step);

   chaser_step_timer #(.PW(PW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .run    (advance),
      .period (period_r),
      .at_end (at_end),
      .step   (step)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (accept) state_nx = RUN;
         RUN: begin
            if (stop)            state_nx = IDLE;
            else if (final_step) state_nx = DONE;
            else if (!enable)    state_nx = HOLD;
         end
         HOLD: begin
            if (stop)        state_nx = IDLE;
            else if (enable) state_nx = RUN;
         end
      endcase
   end

   always_comb begin
      start_pat = '0;
      if (mode_t'(cfg_mode) == ROT_R)      start_pat[WIDTH-1] = 1'b1;
      else if (mode_t'(cfg_mode) != FILL) start_pat[0]       = 1'b1;
   end

   always_comb begin
      led_nx = led_r;
      case (mode_r)
         ROT_L:  led_nx = {led_r[WIDTH-2:0], led_r[WIDTH-1]};
         ROT_R:  led_nx = {led_r[0], led_r[WIDTH-1:1]};
         BOUNCE: led_nx = dir_r ? (led_r >> 1) : (led_r << 1);
         FILL:   led_nx = {led_r[WIDTH-2:0], (step_cnt < SW'(WIDTH))};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_r   <= ROT_L;
         period_r <= '0;
         cycles_r <= '0;
         pass_cnt <= '0;
         step_cnt <= '0;
         dir_r    <= 1'b0;
         led_r    <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= final_step;
         if (accept) begin
            mode_r   <= mode_t'(cfg_mode);
            period_r <= cfg_period;
            cycles_r <= cfg_cycles;
            pass_cnt <= '0;
            step_cnt <= '0;
            dir_r    <= 1'b0;
            led_r    <= start_pat;
         end else if (busy && stop) begin
            led_r <= '0;
         end else if (step) begin
            led_r <= led_nx;
            // dir_r = 1 means moving toward the LSB; it flips on landing at an end bit.
            if (mode_r == BOUNCE) begin
               if (!dir_r && led_nx[WIDTH-1]) dir_r <= 1'b1;
               else if (dir_r && led_nx[0])   dir_r <= 1'b0;
            end
            if (pass_end) begin
               step_cnt <= '0;
               if (!last_pass && cycles_r != '0) pass_cnt <= pass_cnt + CW'(1);
            end else begin
               step_cnt <= step_cnt + SW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_chaser_sequencer.sv
// Directed bench for chaser_sequencer at WIDTH=4 with hand-computed LED sequences.
module tb_chaser_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_period;
   logic [7:0]  cfg_cycles;
   logic        enable;
   logic        stop;
   logic [3:0]  led_out;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] exp_q[$];

   chaser_sequencer #(.WIDTH(4), .PW(16), .CW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_cycles (cfg_cycles),
      .enable     (enable),
      .stop       (stop),
      .led_out    (led_out),
      .busy       (busy),
      .done       (done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic load_cfg(input logic [1:0] m, input logic [15:0] per, input logic [7:0] cyc,
                           input logic [3:0] start);
      cfg_mode   = m;
      cfg_period = per;
      cfg_cycles = cyc;
      cfg_valid  = 1'b1;
      check("cfg_ready_idle", cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
      check("start_led", led_out, start);
      check("busy_start", busy, 1);
      check("ready_low", cfg_ready, 0);
   endtask

   task automatic run_steps(input int period, input int n, input logic [3:0] start, input bit ends_run);
      logic [3:0] cur, nxt;
      int p;
      bit last;
      cur = start;
      p = (period == 0) ? 1 : period;
      for (int s = 0; s < n; s++) begin
         for (int w = 0; w < p - 1; w++) begin
            tick();
            check("hold_led", led_out, cur);
            check("done_mid", done, 0);
         end
         tick();
         if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
            nxt = cur;
         end else begin
            nxt = exp_q.pop_front();
         end
         last = ends_run && (s == n - 1);
         check("step_led", led_out, nxt);
         check("done_step", done, last);
         check("busy_step", busy, !last);
         cur = nxt;
      end
   endtask

   task automatic push4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_period = '0; cfg_cycles = '0;
      enable = 1'b1; stop = 1'b0;
      tick(); tick();
      check("rst_led", led_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", cfg_ready, 1);
      rst = 1'b0;
      tick();

      // ROT_L period 2, one pass
      load_cfg(2'd0, 16'd2, 8'd1, 4'b0001);
      push4(4'b0010, 4'b0100, 4'b1000, 4'b0001);
      run_steps(2, 4, 4'b0001, 1);
      tick();
      check("rotl_done_once", done, 0);
      check("rotl_done_hold", led_out, 4'b0001);
      check("rotl_done_ready", cfg_ready, 1);

      // BOUNCE period 1, two passes, started from DONE
      load_cfg(2'd2, 16'd1, 8'd2, 4'b0001);
      for (int k = 0; k < 2; k++) begin
         push4(4'b0010, 4'b0100, 4'b1000, 4'b0100);
         exp_q.push_back(4'b0010);
         exp_q.push_back(4'b0001);
      end
      run_steps(1, 12, 4'b0001, 1);

      // FILL period 1, one pass
      load_cfg(2'd3, 16'd1, 8'd1, 4'b0000);
      push4(4'b0001, 4'b0011, 4'b0111, 4'b1111);
      push4(4'b1110, 4'b1100, 4'b1000, 4'b0000);
      run_steps(1, 8, 4'b0000, 1);
      tick();

      // ROT_R period 3 free-running, pause mid-step, then stop
      load_cfg(2'd1, 16'd3, 8'd0, 4'b1000);
      tick();
      check("rotr_pre_pause", led_out, 4'b1000);
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("pause_led", led_out, 4'b1000);
         check("pause_busy", busy, 1);
      end
      enable = 1'b1;
      tick(); check("resume_0", led_out, 4'b1000);
      tick(); check("resume_1", led_out, 4'b1000);
      tick(); check("resume_step", led_out, 4'b0100);
      push4(4'b0010, 4'b0001, 4'b1000, 4'b0100);
      exp_q.push_back(4'b0010);
      run_steps(3, 5, 4'b0100, 0);
      stop = 1'b1;
      tick();
      check("stop_led", led_out, 0);
      check("stop_busy", busy, 0);
      check("stop_done", done, 0);
      check("stop_ready", cfg_ready, 1);
      tick();
      check("stop_idle_led", led_out, 0);
      check("stop_idle_ready", cfg_ready, 1);
      stop = 1'b0;

      // cfg_valid held mid-run is ignored
      load_cfg(2'd0, 16'd1, 8'd1, 4'b0001);
      cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_period = 16'd5;
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      run_steps(1, 2, 4'b0001, 0);
      check("held_ready", cfg_ready, 0);
      cfg_valid = 1'b0;
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0001);
      run_steps(1, 2, 4'b0100, 1);

      // stop on the final step, period 0 acting as 1
      load_cfg(2'd0, 16'd0, 8'd1, 4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      run_steps(0, 3, 4'b0001, 0);
      stop = 1'b1;
      tick();
      check("stopfin_led", led_out, 0);
      check("stopfin_done", done, 0);
      check("stopfin_busy", busy, 0);
      stop = 1'b0;
      tick();
      check("stopfin_done2", done, 0);

      // enable low on the final step still completes
      load_cfg(2'd0, 16'd1, 8'd1, 4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      run_steps(1, 3, 4'b0001, 0);
      enable = 1'b0;
      exp_q.push_back(4'b0001);
      run_steps(1, 1, 4'b1000, 1);
      enable = 1'b1;

      // reset mid-run
      load_cfg(2'd2, 16'd1, 8'd0, 4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      run_steps(1, 2, 4'b0001, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_led", led_out, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_ready", cfg_ready, 1);
      check("rstmid_done", done, 0);
      load_cfg(2'd1, 16'd1, 8'd1, 4'b1000);
      exp_q.push_back(4'b0100);
      run_steps(1, 1, 4'b1000, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
